// File: rtl/hex_key_entry.sv
// Hex keypad entry: three debounced buttons build a 32-bit word from eight hex
// digits and deliver it to the CPU through a valid/ack handshake.

module hex_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, debounce and turn each accepted press into a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= '0;
            press      <= 1'b0;
        end else begin
            sync1_r    <= raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press      <= stable_r & ~stable_d_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                // The edge that would reach the threshold flips the level.
                stable_r <= ~stable_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

module hex_key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw,
    input  logic        btn_digit,
    input  logic        btn_commit,
    input  logic        btn_clear,
    input  logic        data_ack,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic [31:0] entry_value,
    output logic [3:0]  digit_count
);

    typedef enum logic [0:0] {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t state_r;
    logic   digit_p_s;
    logic   commit_p_s;
    logic   clear_p_s;

    hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_digit),
        .press (digit_p_s)
    );

    hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_commit),
        .press (commit_p_s)
    );

    hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .press (clear_p_s)
    );

    // Handshake state machine plus entry register; clear beats commit beats digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ENTRY;
            data_out    <= 32'h0000_0000;
            data_valid  <= 1'b0;
            entry_value <= 32'h0000_0000;
            digit_count <= 4'd0;
        end else begin
            case (state_r)
                ST_ENTRY: begin
                    if (commit_p_s && !clear_p_s) begin
                        data_out   <= entry_value;
                        data_valid <= 1'b1;
                        state_r    <= ST_HOLD;
                    end else begin
                        data_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Commit pulses here are dropped, never queued.
                    if (data_ack) begin
                        data_valid <= 1'b0;
                        state_r    <= ST_ENTRY;
                    end else begin
                        data_valid <= 1'b1;
                    end
                end
                default: begin
                    data_valid <= 1'b0;
                    state_r    <= ST_ENTRY;
                end
            endcase

            if (clear_p_s) begin
                entry_value <= 32'h0000_0000;
                digit_count <= 4'd0;
            end else if (commit_p_s) begin
                if (state_r == ST_ENTRY) begin
                    entry_value <= 32'h0000_0000;
                    digit_count <= 4'd0;
                end else begin
                    entry_value <= entry_value;
                    digit_count <= digit_count;
                end
            end else if (digit_p_s && (digit_count < 4'd8)) begin
                entry_value <= {entry_value[27:0], sw};
                digit_count <= digit_count + 4'd1;
            end else begin
                entry_value <= entry_value;
                digit_count <= digit_count;
            end
        end
    end

endmodule

// File: tb/tb_hex_key_entry.sv
// Directed bench for hex_key_entry with a short debounce window.

module tb_hex_key_entry;

    logic        clk;
    logic        reset;
    logic [3:0]  sw;
    logic        btn_digit;
    logic        btn_commit;
    logic        btn_clear;
    logic        data_ack;
    logic [31:0] data_out;
    logic        data_valid;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;

    int total;
    int bad;

    hex_key_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .btn_digit   (btn_digit),
        .btn_commit  (btn_commit),
        .btn_clear   (btn_clear),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .entry_value (entry_value),
        .digit_count (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks also happen there.
    task automatic press(input logic d, input logic c, input logic k, input logic [3:0] v);
        @(negedge clk);
        sw         = v;
        btn_digit  = d;
        btn_commit = c;
        btn_clear  = k;
        repeat (10) @(negedge clk);
        btn_digit  = 1'b0;
        btn_commit = 1'b0;
        btn_clear  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (data_out !== 32'h0 || data_valid !== 1'b0 || entry_value !== 32'h0 || digit_count !== 4'd0) begin
            bad++;
            $display("FAIL reset: out=%h valid=%b entry=%h count=%0d required all zero",
                     data_out, data_valid, entry_value, digit_count);
        end
        sw = 4'hA;
        btn_digit = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        total++;
        if (digit_count !== 4'd0) begin
            bad++;
            $display("FAIL digit_latency_early: count=%0d required 0", digit_count);
        end
        @(negedge clk);
        total++;
        if (entry_value !== 32'h0000_000A || digit_count !== 4'd1) begin
            bad++;
            $display("FAIL digit_latency: entry=%h count=%0d required 0000000a 1", entry_value, digit_count);
        end
        repeat (2) @(negedge clk);
        btn_digit = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (entry_value !== 32'h0000_000A || digit_count !== 4'd1) begin
            bad++;
            $display("FAIL held_single_pulse: entry=%h count=%0d required 0000000a 1", entry_value, digit_count);
        end
    endtask

    task automatic test_bounce;
        sw = 4'h3;
        for (int i = 0; i < 10; i++) begin
            btn_digit = ~btn_digit;
            repeat (2) @(negedge clk);
        end
        btn_digit = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (entry_value !== 32'h0000_000A || digit_count !== 4'd1) begin
            bad++;
            $display("FAIL bounce: entry=%h count=%0d required 0000000a 1", entry_value, digit_count);
        end
    endtask

    task automatic test_full_entry;
        press(1'b0, 1'b0, 1'b1, 4'h0);
        total++;
        if (entry_value !== 32'h0 || digit_count !== 4'd0) begin
            bad++;
            $display("FAIL clear: entry=%h count=%0d required 0 0", entry_value, digit_count);
        end
        for (int i = 1; i <= 8; i++) press(1'b1, 1'b0, 1'b0, 4'(i));
        total++;
        if (entry_value !== 32'h1234_5678 || digit_count !== 4'd8) begin
            bad++;
            $display("FAIL full_entry: entry=%h count=%0d required 12345678 8", entry_value, digit_count);
        end
        press(1'b1, 1'b0, 1'b0, 4'h9);
        total++;
        if (entry_value !== 32'h1234_5678 || digit_count !== 4'd8) begin
            bad++;
            $display("FAIL overflow: entry=%h count=%0d required 12345678 8", entry_value, digit_count);
        end
    endtask

    task automatic test_commit;
        int hold_bad;
        hold_bad = 0;
        press(1'b0, 1'b1, 1'b0, 4'h0);
        total++;
        if (data_valid !== 1'b1 || data_out !== 32'h1234_5678 || entry_value !== 32'h0 || digit_count !== 4'd0) begin
            bad++;
            $display("FAIL commit: valid=%b out=%h entry=%h count=%0d required 1 12345678 0 0",
                     data_valid, data_out, entry_value, digit_count);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b1 || data_out !== 32'h1234_5678) hold_bad++;
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL commit_hold: %0d cycles lost valid/data, required 0", hold_bad);
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        total++;
        if (data_valid !== 1'b0 || data_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ack: valid=%b out=%h required 0 12345678", data_valid, data_out);
        end
        data_ack = 1'b1;
        repeat (2) @(negedge clk);
        data_ack = 1'b0;
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL ack_in_entry: valid=%b required 0", data_valid);
        end
    endtask

    task automatic test_hold;
        press(1'b1, 1'b0, 1'b0, 4'h5);
        press(1'b0, 1'b1, 1'b0, 4'h0);
        total++;
        if (data_valid !== 1'b1 || data_out !== 32'h0000_0005) begin
            bad++;
            $display("FAIL hold_enter: valid=%b out=%h required 1 00000005", data_valid, data_out);
        end
        press(1'b1, 1'b0, 1'b0, 4'hF);
        press(1'b0, 1'b1, 1'b0, 4'h0);
        total++;
        if (entry_value !== 32'h0000_000F || digit_count !== 4'd1 || data_out !== 32'h0000_0005 || data_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_commit_dropped: entry=%h count=%0d out=%h valid=%b required f 1 5 1",
                     entry_value, digit_count, data_out, data_valid);
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        press(1'b0, 1'b1, 1'b0, 4'h0);
        total++;
        if (data_out !== 32'h0000_000F || data_valid !== 1'b1 || entry_value !== 32'h0) begin
            bad++;
            $display("FAIL recommit: out=%h valid=%b entry=%h required 0000000f 1 0", data_out, data_valid, entry_value);
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    task automatic test_priority;
        press(1'b1, 1'b0, 1'b0, 4'h3);
        press(1'b1, 1'b0, 1'b1, 4'h7);
        total++;
        if (entry_value !== 32'h0 || digit_count !== 4'd0) begin
            bad++;
            $display("FAIL clear_over_digit: entry=%h count=%0d required 0 0", entry_value, digit_count);
        end
        press(1'b1, 1'b0, 1'b0, 4'h3);
        press(1'b1, 1'b1, 1'b0, 4'h7);
        total++;
        if (data_out !== 32'h0000_0003 || data_valid !== 1'b1 || entry_value !== 32'h0 || digit_count !== 4'd0) begin
            bad++;
            $display("FAIL commit_over_digit: out=%h valid=%b entry=%h count=%0d required 3 1 0 0",
                     data_out, data_valid, entry_value, digit_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (data_valid !== 1'b0 || data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_in_hold: valid=%b out=%h required 0 0", data_valid, data_out);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        sw         = 4'h0;
        btn_digit  = 1'b0;
        btn_commit = 1'b0;
        btn_clear  = 1'b0;
        data_ack   = 1'b0;
        test_reset();
        test_bounce();
        test_full_entry();
        test_commit();
        test_hold();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
